// File: rtl/tictactoe_board.sv
// Board-state owner for tic-tac-toe: validates moves, writes cells, judges win/draw from the detector.
// Latency: ack/err one cycle after acceptance; turn/game_over settle one cycle later (CHECK).
// Backpressure: move_ready is high only in PLAY; requests in CHECK/OVER are ignored, not queued.
module tictactoe_board (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_ack,
  output logic       move_err,
  input  logic       win_in,
  input  logic [1:0] winner_in,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] result,
  output logic       draw
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [1:0] r_board [9];
  logic [1:0] r_turn;
  logic [3:0] r_count;
  logic [1:0] r_result;
  logic       r_draw;
  logic       r_ack;
  logic       r_err;

  logic       w_clear;
  logic       w_accept;
  logic       w_legal;
  logic       w_full;
  logic [8:0] w_sel;
  logic [8:0] w_free;

  // rst and new_game are interchangeable full clears
  assign w_clear  = rst | new_game;
  // an out-of-range position selects no cell, so it can never look free
  assign w_accept = (r_state == ST_PLAY) && move_valid && !w_clear;
  assign w_legal  = w_accept && |(w_sel & w_free);
  assign w_full   = (r_count == 4'd9);

  // one-hot decode of the requested cell and per-cell emptiness
  always_comb begin
    w_sel  = '0;
    w_free = '0;
    for (int i = 0; i < 9; i++) begin
      w_sel[i]  = (move_pos == 4'(i + 1));
      w_free[i] = (r_board[i] == 2'b00);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= ST_PLAY;
    else         r_state <= w_state_nxt;
  end

  // next-state: a legal move forces a one-cycle CHECK before the next move
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PLAY:  if (w_legal) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = (win_in || w_full) ? ST_OVER : ST_PLAY;
      ST_OVER:  w_state_nxt = ST_OVER;
      default:  w_state_nxt = ST_PLAY;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    move_ready = (r_state == ST_PLAY);
    game_over  = (r_state == ST_OVER);
  end

  // board, turn, counters and result; a win on the last move outranks the draw
  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int i = 0; i < 9; i++) r_board[i] <= 2'b00;
      r_turn   <= 2'b01;
      r_count  <= 4'd0;
      r_result <= 2'b00;
      r_draw   <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= w_legal;
      r_err <= w_accept && !w_legal;
      if (w_legal) begin
        for (int i = 0; i < 9; i++) begin
          if (w_sel[i]) r_board[i] <= r_turn;
        end
        if (!w_full) r_count <= r_count + 4'd1;
      end
      if (r_state == ST_CHECK) begin
        if (win_in) begin
          r_result <= winner_in;
          r_draw   <= 1'b0;
        end else if (w_full) begin
          r_draw   <= 1'b1;
        end else begin
          r_turn   <= ~r_turn;
        end
      end
    end
  end

  assign move_ack   = r_ack;
  assign move_err   = r_err;
  assign turn       = r_turn;
  assign move_count = r_count;
  assign result     = r_result;
  assign draw       = r_draw;
  assign pos1       = r_board[0];
  assign pos2       = r_board[1];
  assign pos3       = r_board[2];
  assign pos4       = r_board[3];
  assign pos5       = r_board[4];
  assign pos6       = r_board[5];
  assign pos7       = r_board[6];
  assign pos8       = r_board[7];
  assign pos9       = r_board[8];

endmodule
